apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB master: accepts one command at a time and runs a SETUP/ACCESS transfer to one of NSLV slaves.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      paddr,
    output logic                   pwrite,
    output logic [DATA_W-1:0]      pwdata,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    input  logic [NSLV*DATA_W-1:0] prdata,
    input  logic [NSLV-1:0]        pready,
    input  logic [NSLV-1:0]        pslverr
);

    localparam int SW = $clog2(NSLV);

    if (NSLV < 2 || (1 << SW) != NSLV || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("apb_master: NSLV must be a power of two >= 2 and TIMEOUT in 1..255");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   cmd_sel;
    logic            sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic            accept;
    logic            timeout;

    assign cmd_sel   = cmd_addr[ADDR_W-1 -: SW];
    assign sel_ready = pready[sel];
    assign sel_rdata = prdata[int'(sel)*DATA_W +: DATA_W];

    // A ready slave always wins over the timeout, so ACCESS acceptance only needs pready[s].
    assign cmd_ready = !rst && ((state == IDLE) || (state == ACCESS && sel_ready));
    assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] tcnt;
    assign timeout = (state == ACCESS) && !sel_ready && (tcnt == 8'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    psel    <= '0;
                    penable <= 1'b0;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr[sel];
                        rsp_rdata <= (!pwrite && !pslverr[sel]) ? sel_rdata : '0;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else if (timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else begin
                        tcnt <= tcnt + 8'd1;
                    end
`endif
                end
                default: begin
                    psel    <= '0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase

            // Acceptance (from IDLE or on ACCESS completion) overrides the IDLE fallback above.
            if (accept) begin
                sel     <= cmd_sel;
                paddr   <= cmd_addr;
                pwrite  <= cmd_write;
                pwdata  <= cmd_wdata;
                psel    <= NSLV'(1) << cmd_sel;
                penable <= 1'b0;
                state   <= SETUP;
            end
        end
    end

endmodule
